treeval_ctrl: RTL
=================

# treeval_ctrl

Sequencing controller for the `treeval` backward-propagation datapath. It accepts a host stream of node records and programs the node count into `treeval`. It clears the datapath rewards, then writes every node's weight, parent and reward through the `treeval` memory strobes. After loading, it waits for a complete propagation sweep and returns the root expectation to the host through a valid/ready result port, with timeout detection.

## Interface
- `W_ADDR`, 10, node address width (matches `treeval`)
- `W_M_DATA`, 10, `mem_data` width; must be ≥ max(`W_ADDR`, `W_REWARD`, 7)
- `W_C_DATA`, 10, node-count/config width
- `W_REWARD`, 8, signed reward width
- `TIMEOUT`, 4096, max RUN cycles before error

- `clk`  in  1  clock
- `rst`  in  1  reset rst, synchronous, active-high
- `start`  in  1  begin a job; sampled only in IDLE
- `cfg_nodes`  in  W_C_DATA  index of last node N; nodes 0..N are loaded; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `in_valid`  in  1  node record valid
- `in_ready`  out  1  record accepted when `in_valid & in_ready`
- `in_parent`  in  W_ADDR  parent address
- `in_reward`  in  W_REWARD  signed reward
- `in_weight`  in  7  unsigned weight
- `dp_rst`  out  1  one-cycle reward clear to `treeval`
- `conf_nodes`  out  1  config strobe
- `conf_data`  out  W_C_DATA  node count
- `mem_weight`, `mem_par`, `mem_rew`  out  1 each  write strobes; at most one high per cycle
- `mem_addr`  out  W_ADDR  target node
- `mem_data`  out  W_M_DATA  write data
- `exp_change`  in  1  sweep-complete indication from `treeval`
- `exp`  in  W_REWARD  root expectation from `treeval`
- `res_valid`  out  1  result available
- `res_exp`  out  W_REWARD  captured expectation
- `res_err`  out  1  result invalid (timeout); qualified by `res_valid`
- `res_ready`  in  1  host consumes result

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- States: IDLE, CONF, CLEAR, ACC, WR_W, WR_P, WR_R, RUN, DONE.
- IDLE → CONF on `start`. The controller latches `cfg_nodes` and sets the address counter to 0.
- CONF: `conf_nodes`=1 and `conf_data`=latched N for one cycle. Then → CLEAR.
- CLEAR: `dp_rst`=1 for one cycle. Then → ACC.
- ACC: `in_ready`=1. On handshake, the record is captured into a holding register. Then → WR_W.
- WR_W: `mem_weight`=1, `mem_data`=weight zero-extended.
- WR_P: `mem_par`=1, `mem_data`=parent zero-extended.
- WR_R: `mem_rew`=1, `mem_data`=reward sign-extended.
- `mem_addr` holds the counter throughout WR_W, WR_P and WR_R.
- After WR_R: if counter == N → RUN; else counter+1 → ACC.
- RUN:
  - Detect rising edges of `exp_change`.
  - The first edge is discarded, because that sweep may have overlapped loading.
  - On the second edge, `exp` is captured into `res_exp` in that same cycle, `res_err`=0 → DONE.
  - A cycle counter starts at RUN entry. If it reaches `TIMEOUT`, `res_err`=1, `res_exp`=0 → DONE.
- DONE: `res_valid`=1, and `res_exp`/`res_err` hold stable. On `res_ready` → IDLE, clearing `res_valid`.
- `start` is ignored in every state except IDLE.
- `rst` mid-job: the next edge forces IDLE, drops all strobes and `in_ready`, and discards partial loads. No `dp_rst` is issued on reset.
- N=0: a single record is loaded, then → RUN.

## Timing
- `start` at cycle t: `conf_nodes` at t+1, `dp_rst` at t+2, `in_ready` from t+3.
- Record accepted at cycle a: `mem_weight` at a+1, `mem_par` at a+2, `mem_rew` at a+3. `in_ready` is high again at a+4, or RUN begins at a+4 after the last record.
- Peak load throughput: 1 record per 4 cycles. Input gaps stall in ACC indefinitely; no timeout applies during loading.
- Strobes change at posedge and are stable across the following negedge, when `treeval` captures.
- `res_valid` rises the cycle after the capturing edge. It falls the cycle after `res_ready`.

## Structure
- `treeval_pkg`: FSM state enum, node-record struct {parent, reward, weight}, and constant `WEIGHT_W`=7 shared with `treeval`.
- One natural sub-module: `treeval_ctrl_timer`, a loadable down-counter with an expiry flag, used for the RUN timeout.

## Test plan
- N=2, records (p0,r0,w0), (p0,r10,w64), (p0,r-5,w64): 9 strobes at addresses 0,0,0,1,1,1,2,2,2 in W,P,R order. `mem_data` for reward -5 equals 0x3FB.
- Backpressure: `in_valid` low for 5 cycles between records → `in_ready` stays high, no strobes occur, and the strobe sequence is otherwise unchanged.
- Completion: after loading, pulse `exp_change` twice with `exp`=37 on the second pulse → `res_valid`=1, `res_exp`=37, `res_err`=0. The result is held until `res_ready`.
- Timeout: `TIMEOUT`=16 with no `exp_change` → `res_valid` 16 cycles after RUN entry, `res_err`=1, `res_exp`=0.
- `rst` asserted during WR_P of node 1 → all outputs 0 the next cycle, state IDLE. A new `start` restarts from CONF at address 0.
- `start` pulsed during ACC and DONE → no effect. The latched N and the counter are unchanged.

Source files
------------

// File: rtl/treeval_pkg.sv
// treeval_pkg: shared widths, FSM state codes and node record for treeval_ctrl
package treeval_pkg;
  localparam int WEIGHT_W = 7;
  localparam int ADDR_W = 10;
  localparam int REWARD_W = 8;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE  = 4'd0;
  localparam state_t S_CONF  = 4'd1;
  localparam state_t S_CLEAR = 4'd2;
  localparam state_t S_ACC   = 4'd3;
  localparam state_t S_WR_W  = 4'd4;
  localparam state_t S_WR_P  = 4'd5;
  localparam state_t S_WR_R  = 4'd6;
  localparam state_t S_RUN   = 4'd7;
  localparam state_t S_DONE  = 4'd8;
  typedef struct packed {
    logic [ADDR_W-1:0]   parent;
    logic [REWARD_W-1:0] reward;
    logic [WEIGHT_W-1:0] weight;
  } node_t;
endpackage

// File: rtl/treeval_ctrl_timer.sv
// treeval_ctrl_timer: loadable down-counter whose expiry flag marks count zero
module treeval_ctrl_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         expired
);
  logic [W-1:0] cnt;
  assign expired = cnt == '0;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && !expired) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/treeval_ctrl.sv
// treeval_ctrl: loads node records into treeval, waits for a clean sweep, returns the root expectation
module treeval_ctrl
  import treeval_pkg::*;
#(
  parameter int W_ADDR   = 10,
  parameter int W_M_DATA = 10,
  parameter int W_C_DATA = 10,
  parameter int W_REWARD = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [W_C_DATA-1:0]        cfg_nodes,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_ADDR-1:0]          in_parent,
  input  logic signed [W_REWARD-1:0] in_reward,
  input  logic [WEIGHT_W-1:0]        in_weight,
  output logic                       dp_rst,
  output logic                       conf_nodes,
  output logic [W_C_DATA-1:0]        conf_data,
  output logic                       mem_weight,
  output logic                       mem_par,
  output logic                       mem_rew,
  output logic [W_ADDR-1:0]          mem_addr,
  output logic [W_M_DATA-1:0]        mem_data,
  input  logic                       exp_change,
  input  logic signed [W_REWARD-1:0] exp,
  output logic                       res_valid,
  output logic signed [W_REWARD-1:0] res_exp,
  output logic                       res_err,
  input  logic                       res_ready
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  node_t hold, hold_n;
  logic [W_C_DATA-1:0] n_lat, n_n, cnt, cnt_n;
  logic [W_M_DATA-1:0] data_n;
  logic exp_q, seen, rise, hit, expired;
  treeval_ctrl_timer #(.W(TW)) u_timer (
    .clk,
    .rst,
    .load(state != S_RUN),
    .en(state == S_RUN),
    .val(TW'(TIMEOUT - 1)),
    .expired
  );
  assign rise = exp_change & ~exp_q;
  assign hit = rise & seen;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_CONF : S_IDLE;
      S_CONF:  state_n = S_CLEAR;
      S_CLEAR: state_n = S_ACC;
      S_ACC:   state_n = (in_valid & in_ready) ? S_WR_W : S_ACC;
      S_WR_W:  state_n = S_WR_P;
      S_WR_P:  state_n = S_WR_R;
      S_WR_R:  state_n = (cnt == n_lat) ? S_RUN : S_ACC;
      S_RUN:   state_n = (hit | expired) ? S_DONE : S_RUN;
      S_DONE:  state_n = res_ready ? S_IDLE : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // Outputs are registered from next-state values so strobes line up with the state they belong to
  always_comb begin
    n_n = (state == S_IDLE && start) ? cfg_nodes : n_lat;
    cnt_n = (state == S_IDLE && start) ? '0 : (state == S_WR_R && state_n == S_ACC) ? cnt + 1'b1 : cnt;
    hold_n = (state == S_ACC && in_valid && in_ready) ?
      '{parent: ADDR_W'(in_parent), reward: REWARD_W'(in_reward), weight: in_weight} : hold;
    data_n = state_n == S_WR_W ? W_M_DATA'(hold_n.weight) :
             state_n == S_WR_P ? W_M_DATA'(hold_n.parent) :
             state_n == S_WR_R ? W_M_DATA'($signed(hold_n.reward)) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      cnt        <= '0;
      hold       <= '0;
      exp_q      <= 1'b0;
      seen       <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      dp_rst     <= 1'b0;
      conf_nodes <= 1'b0;
      conf_data  <= '0;
      mem_weight <= 1'b0;
      mem_par    <= 1'b0;
      mem_rew    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      res_valid  <= 1'b0;
      res_exp    <= '0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_n;
      n_lat      <= n_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      exp_q      <= exp_change;
      seen       <= (state == S_RUN) && (seen || rise);
      busy       <= state_n != S_IDLE;
      in_ready   <= state_n == S_ACC;
      dp_rst     <= state_n == S_CLEAR;
      conf_nodes <= state_n == S_CONF;
      conf_data  <= state_n == S_CONF ? n_n : '0;
      mem_weight <= state_n == S_WR_W;
      mem_par    <= state_n == S_WR_P;
      mem_rew    <= state_n == S_WR_R;
      mem_addr   <= W_ADDR'(cnt_n);
      mem_data   <= data_n;
      res_valid  <= state_n == S_DONE;
      if (state == S_RUN && state_n == S_DONE) begin
        res_exp <= hit ? exp : '0;
        res_err <= ~hit;
      end
    end
  end
endmodule
